mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter that shares one byte-wide data-memory-style port (8-bit address, combinational read, write on `posedge clk`) between an instruction-fetch requester and a load/store requester. It sequences each 16-bit fetch as two byte reads: the high byte at `addr`, then the low byte at `addr+1`. It serves one 8-bit load or store per grant and arbitrates round-robin when both requesters are pending. It sits between the CPU front-end/execute stages and the unified 256-byte memory.

## Interface
- No parameters. Address width is fixed at 8, data at 8, instruction at 16.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request, level; held until `if_valid`.
- `if_addr` in 8: fetch byte address; stable while `if_req` is high.
- `if_instr` out 16: fetched instruction `{mem[a], mem[a+1]}`; holds its value between fetches.
- `if_valid` out 1: one-cycle pulse; `if_instr` is valid this cycle.
- `d_req` in 1: data request, level; held until `d_valid`.
- `d_we` in 1: 1 = store, 0 = load; stable with `d_req`.
- `d_addr` in 8, `d_wdata` in 8: data address and store data; stable with `d_req`.
- `d_rdata` out 8: load result; holds its value between loads and is unchanged by stores.
- `d_valid` out 1: one-cycle pulse on completion of a load or store.
- `mem_addr` out 8, `mem_wdata` out 8, `mem_read` out 1, `mem_write` out 1: memory-side controls, combinational from state.
- `mem_rdata` in 8: memory read data, combinational from `mem_addr`.

## Operation
- States: IDLE, IF_HI, IF_LO, DATA. A registered `last_grant` bit (0 = fetch, 1 = data) holds the last port served.
- IDLE: evaluates effective requests `if_req & ~if_valid` and `d_req & ~d_valid`. The current-cycle valid masks the completing port, so a held request is not double-issued.
  - Only fetch pending -> IF_HI.
  - Only data pending -> DATA.
  - Both pending -> grant the port not equal to `last_grant`, then update `last_grant`.
  - None pending -> stay in IDLE.
- IF_HI: `mem_addr=if_addr`, `mem_read=1`. Captures `mem_rdata` into the high byte, then -> IF_LO.
- IF_LO: `mem_addr=if_addr+1` as an 8-bit sum (0xFF wraps to 0x00), `mem_read=1`. Captures the low byte, registers `if_instr`, sets `if_valid` for the next cycle, then -> IDLE.
- DATA:
  - Load: `mem_addr=d_addr`, `mem_read=1`. Registers `d_rdata<=mem_rdata`.
  - Store: `mem_addr=d_addr`, `mem_wdata=d_wdata`, `mem_write=1`.
  - Either case: sets `d_valid` for the next cycle, then -> IDLE.
- `mem_read` and `mem_write` are never both 1. Only one memory access happens per cycle.
- In IDLE: `mem_addr=0`, `mem_wdata=0`, `mem_read=0`, `mem_write=0`.
- Grants are non-preemptive. A fetch always completes both byte reads before data is served.
- Request drop mid-transaction is illegal. Behaviour is defined only for held requests, and the arbiter does not check for drops.

## Timing
- Fetch latency: `if_req` sampled in IDLE at cycle 0 -> IF_HI at cycle 1 -> IF_LO at cycle 2 -> `if_valid=1` at cycle 3 (arbiter is back in IDLE in that cycle).
- Load/store latency: sampled at cycle 0 -> DATA at cycle 1 -> `d_valid=1` at cycle 2. The store commits to memory at the end of cycle 1.
- Back-to-back: the IDLE cycle that carries a valid pulse also arbitrates. Throughput is one fetch per 3 cycles or one data access per 2 cycles.
- Reset values: state=IDLE, `last_grant=1` (fetch wins the first tie), `if_instr=16'h0000`, `d_rdata=8'h00`, `if_valid=0`, `d_valid=0`, all `mem_*` outputs 0.
- While `rst=1`, `mem_read` and `mem_write` are forced to 0 combinationally. A store in DATA during a reset cycle is therefore dropped.
- Reset mid-transaction: the arbiter returns to IDLE after the reset edge, no valid pulse is generated, and any partial fetch is discarded. The requester must re-present its request after reset.

## Test plan
- Memory preloaded with mem[0x10]=0xAB, mem[0x11]=0xCD; `if_req=1`, `if_addr=0x10` -> `if_valid` pulses at cycle 3 with `if_instr=0xABCD`; `mem_addr` reads 0x10, then 0x11.
- Wrap: mem[0xFF]=0x12, mem[0x00]=0x34, `if_addr=0xFF` -> `if_instr=0x1234`; the second read has `mem_addr=0x00`.
- Store then load: `d_we=1`, `d_addr=0x40`, `d_wdata=0x5A` -> `d_valid` at cycle 2 and `mem_write` high for exactly 1 cycle. A following load of 0x40 -> `d_rdata=0x5A` and `d_valid` 2 cycles after grant.
- Contention: `if_req` and `d_req` both held from reset -> order is fetch, data, fetch, data; each `if_valid` and `d_valid` is a single-cycle pulse; no double issue.
- Reset mid-fetch: assert `rst` in IF_LO -> no `if_valid`, `if_instr` returns to 0x0000, state IDLE; after reset the held request completes normally.
- Reset during store: `rst=1` while in DATA with `d_we=1` -> `mem_write=0`, the memory location is unchanged, and no `d_valid`.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory port between a 16-bit
// instruction fetch (two byte reads, high byte first) and 8-bit loads/stores.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic [15:0] if_instr,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [7:0]  d_addr,
  input  logic [7:0]  d_wdata,
  output logic [7:0]  d_rdata,
  output logic        d_valid,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_IF_HI, S_IF_LO, S_DATA} state_t;

  state_t      r_state, w_next_state;
  logic        r_last_grant, w_next_grant;
  logic [7:0]  r_hi_byte;
  logic [15:0] r_if_instr;
  logic [7:0]  r_d_rdata;
  logic        r_if_valid, r_d_valid;
  logic        w_if_pend, w_d_pend;
  logic        w_mem_read, w_mem_write;

  // The valid pulse of the port completing this cycle masks its still-held request.
  assign w_if_pend = if_req & ~r_if_valid;
  assign w_d_pend  = d_req & ~r_d_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_grant;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_last_grant;
    unique case (r_state)
      S_IDLE: begin
        if (w_if_pend && (!w_d_pend || r_last_grant)) begin
          w_next_state = S_IF_HI;
          w_next_grant = 1'b0;
        end else if (w_d_pend) begin
          w_next_state = S_DATA;
          w_next_grant = 1'b1;
        end
      end
      S_IF_HI: w_next_state = S_IF_LO;
      S_IF_LO: w_next_state = S_IDLE;
      S_DATA:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    unique case (r_state)
      S_IF_HI: begin
        mem_addr   = if_addr;
        w_mem_read = 1'b1;
      end
      S_IF_LO: begin
        mem_addr   = if_addr + 8'd1;
        w_mem_read = 1'b1;
      end
      S_DATA: begin
        mem_addr = d_addr;
        if (d_we) begin
          mem_wdata   = d_wdata;
          w_mem_write = 1'b1;
        end else begin
          w_mem_read = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset blocks memory strobes immediately so an in-flight store is dropped.
  assign mem_read  = w_mem_read & ~rst;
  assign mem_write = w_mem_write & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi_byte  <= '0;
      r_if_instr <= '0;
      r_d_rdata  <= '0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
    end else begin
      r_if_valid <= (r_state == S_IF_LO);
      r_d_valid  <= (r_state == S_DATA);
      if (r_state == S_IF_HI)
        r_hi_byte <= mem_rdata;
      if (r_state == S_IF_LO)
        r_if_instr <= {r_hi_byte, mem_rdata};
      if (r_state == S_DATA && !d_we)
        r_d_rdata <= mem_rdata;
    end
  end

  assign if_instr = r_if_instr;
  assign if_valid = r_if_valid;
  assign d_rdata  = r_d_rdata;
  assign d_valid  = r_d_valid;

endmodule
